dmem_responder: RTL and testbench

Data-memory responder serving the CPU core's data port (`daddr`/`dwrite`/`dD`/`mem_read` in, `dQ`/`wait_state` out). Lower three quarters of the data address space map to an internal single-port RAM with one-cycle registered read and zero wait states. The top quarter maps to an I/O window bridged to a slow peripheral bus with a req/ack handshake. `wait_state` stalls the core until the peripheral acknowledges or a timeout expires.

---
 rtl/dmem_responder.sv | 158 +++++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU core's data port.
// Addresses whose top two bits are not 2'b11 hit an internal single-port RAM
// (registered read, read-first, no wait states). Addresses in the top quarter
// are forwarded to a slow peripheral bus over a req/ack handshake. The core
// is stalled until the peripheral acknowledges or the request times out.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   daddr, dwrite, dD,    core data-port request (address, write strobe,
//   mem_read              write data, read strobe)
//   dQ                    registered read data back to the core
//   wait_state            combinational stall to the core
//   io_req, io_we,        registered peripheral request, write enable,
//   io_addr, io_wdata     word address and write data
//   io_rdata, io_ack      peripheral read data and completion
//   io_err                one-cycle pulse when a request times out
module dmem_responder #(
  parameter int unsigned width       = 16,
  parameter int unsigned daddr_width = 8,
  parameter int unsigned io_timeout  = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [daddr_width-1:0] daddr,
  input  logic                   dwrite,
  input  logic [width-1:0]       dD,
  input  logic                   mem_read,
  output logic [width-1:0]       dQ,
  output logic                   wait_state,
  output logic                   io_req,
  output logic                   io_we,
  output logic [daddr_width-3:0] io_addr,
  output logic [width-1:0]       io_wdata,
  input  logic [width-1:0]       io_rdata,
  input  logic                   io_ack,
  output logic                   io_err
);

  localparam int unsigned RAM_DEPTH = 3 * (2 ** (daddr_width - 2));
  localparam int unsigned CW        = $clog2(io_timeout + 1);
  // Counter holds (IO_REQ cycles elapsed - 1); the last allowed cycle is
  // therefore reached when it equals io_timeout-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(io_timeout - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IO_REQ  = 2'd1,
    IO_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [width-1:0]       r_ram [0:RAM_DEPTH-1];
  logic [width-1:0]       r_dq;
  logic                   r_req;
  logic                   r_we;
  logic [daddr_width-3:0] r_addr;
  logic [width-1:0]       r_wdata;
  logic                   r_err;
  logic [CW-1:0]          r_cnt;

  logic w_io_sel;
  logic w_access;
  logic w_wait;
  logic w_start;
  logic w_ack;
  logic w_tmo;
  logic w_ram_wr;
  logic w_ram_rd;

  assign w_io_sel = (daddr[daddr_width-1:daddr_width-2] == 2'b11);
  assign w_access = dwrite | mem_read;
  assign w_ram_wr = dwrite & ~w_io_sel;
  assign w_ram_rd = mem_read & ~w_io_sel;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_wait  = 1'b0;
    w_start = 1'b0;
    w_ack   = 1'b0;
    w_tmo   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_io_sel && w_access) begin
          w_wait  = 1'b1;
          w_start = 1'b1;
          w_next  = IO_REQ;
        end
      end
      IO_REQ: begin
        w_wait = 1'b1;
        // Ack takes priority over a timeout landing in the same cycle.
        if (io_ack) begin
          w_ack  = 1'b1;
          w_next = IO_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo  = 1'b1;
          w_next = IO_DONE;
        end
      end
      IO_DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (reset) begin
      w_wait  = 1'b0;
      w_start = 1'b0;
      w_ack   = 1'b0;
      w_tmo   = 1'b0;
    end
  end

  // RAM array carries no reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ram_wr) r_ram[daddr] <= dD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dq    <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_err <= w_tmo;
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= dwrite;
        r_addr  <= daddr[daddr_width-3:0];
        r_wdata <= dD;
        r_cnt   <= '0;
      end else if (r_state == IO_REQ) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_ack || w_tmo) r_req <= 1'b0;

      if (w_ack && !r_we)      r_dq <= io_rdata;
      else if (w_tmo && !r_we) r_dq <= '1;
      else if (w_ram_rd)       r_dq <= r_ram[daddr];
    end
  end

  assign dQ         = r_dq;
  assign wait_state = w_wait;
  assign io_req     = r_req;
  assign io_we      = r_we;
  assign io_addr    = r_addr;
  assign io_wdata   = r_wdata;
  assign io_err     = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  daddr;
  logic        dwrite;
  logic [15:0] dD;
  logic        mem_read;
  logic [15:0] dQ;
  logic        wait_state;
  logic        io_req;
  logic        io_we;
  logic [5:0]  io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        io_ack;
  logic        io_err;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(
    .width(16),
    .daddr_width(8),
    .io_timeout(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .daddr(daddr),
    .dwrite(dwrite),
    .dD(dD),
    .mem_read(mem_read),
    .dQ(dQ),
    .wait_state(wait_state),
    .io_req(io_req),
    .io_we(io_we),
    .io_addr(io_addr),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .io_ack(io_ack),
    .io_err(io_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    daddr    = 8'h00;
    dwrite   = 1'b0;
    mem_read = 1'b0;
    dD       = 16'h0000;
    io_ack   = 1'b0;
  endtask

  // Presents one I/O access and runs until wait_state drops (IO_DONE cycle).
  // ack_at = IO_REQ cycle number carrying io_ack (0 = never).
  task automatic io_access(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                           input int ack_at, input logic [15:0] rd,
                           output int waits, output int errs, output int stable);
    logic [5:0] a6;
    int cyc;
    a6 = addr[5:0];
    waits = 0; errs = 0; stable = 0; cyc = 0;
    daddr = addr; dwrite = we; mem_read = ~we; dD = wd;
    io_rdata = rd; io_ack = 1'b0;
    #1;
    while (wait_state && cyc < 40) begin
      waits++;
      tick();
      cyc++;
      io_ack = (cyc == ack_at);
      #1;
      if (io_err) errs++;
      if (io_req && io_we == we && io_addr == a6 && io_wdata == wd) stable++;
    end
    if (cyc >= 40) check("io_wait_bound", 32'(cyc), 32'd39);
  endtask

  task automatic end_access();
    idle_inputs();
    tick();
    #1;
    check("err_after_done", 32'(io_err), 32'd0);
  endtask

  int waits, errs, stable;

  initial begin
    idle_inputs();
    io_rdata = 16'h0000;
    reset = 1'b1;
    tick(); tick();
    // wait_state must stay low under reset even with an I/O access presented
    daddr = 8'hC0; mem_read = 1'b1; #1;
    check("wait_in_reset", 32'(wait_state), 32'd0);
    tick();
    idle_inputs();
    reset = 1'b0;
    #1;
    check("rst_dQ", 32'(dQ), 32'h0);
    check("rst_io_req", 32'(io_req), 32'd0);
    check("rst_io_we", 32'(io_we), 32'd0);
    check("rst_io_addr", 32'(io_addr), 32'd0);
    check("rst_io_wdata", 32'(io_wdata), 32'd0);
    check("rst_io_err", 32'(io_err), 32'd0);
    check("rst_wait", 32'(wait_state), 32'd0);

    // RAM write then read, zero wait
    tick();
    daddr = 8'h05; dwrite = 1'b1; dD = 16'h1234; #1;
    check("ram_wr_wait", 32'(wait_state), 32'd0);
    tick();
    dwrite = 1'b0; mem_read = 1'b1; #1;
    check("ram_rd_wait", 32'(wait_state), 32'd0);
    tick();
    check("ram_rd_05", 32'(dQ), 32'h1234);
    mem_read = 1'b0;

    // Read-first at 0x10
    daddr = 8'h10; dwrite = 1'b1; dD = 16'h0001;
    tick();
    mem_read = 1'b1; dD = 16'hBEEF;
    tick();
    check("ram_rd_first", 32'(dQ), 32'h0001);
    dwrite = 1'b0;
    tick();
    check("ram_rd_after", 32'(dQ), 32'hBEEF);

    // Last RAM word 0xBF
    mem_read = 1'b0; daddr = 8'hBF; dwrite = 1'b1; dD = 16'h7E7E;
    tick();
    dwrite = 1'b0; mem_read = 1'b1;
    tick();
    check("ram_rd_bf", 32'(dQ), 32'h7E7E);
    check("ram_05_hold", 32'(dQ != 16'h1234), 32'd1);
    idle_inputs();
    // Stray ack in IDLE has no effect
    io_ack = 1'b1; io_rdata = 16'hDEAD;
    tick();
    io_ack = 1'b0; #1;
    check("idle_ack_dQ", 32'(dQ), 32'h7E7E);
    check("idle_ack_req", 32'(io_req), 32'd0);

    // I/O read at 0xC3 acked in IO_REQ cycle 3
    io_access(1'b0, 8'hC3, 16'h0000, 3, 16'h00A5, waits, errs, stable);
    check("ior_waits", 32'(waits), 32'd4);
    check("ior_stable", 32'(stable), 32'd3);
    check("ior_errs", 32'(errs), 32'd0);
    check("ior_dQ", 32'(dQ), 32'h00A5);
    check("ior_done_req", 32'(io_req), 32'd0);
    end_access();

    // I/O write at 0xFF never acked -> timeout
    io_access(1'b1, 8'hFF, 16'h5555, 0, 16'h0000, waits, errs, stable);
    check("iow_tmo_waits", 32'(waits), 32'd16);
    check("iow_tmo_stable", 32'(stable), 32'd15);
    check("iow_tmo_errs", 32'(errs), 32'd1);
    check("iow_tmo_err_done", 32'(io_err), 32'd1);
    check("iow_tmo_dQ", 32'(dQ), 32'h00A5);
    end_access();

    // I/O read never acked -> all ones
    io_access(1'b0, 8'hC7, 16'h0000, 0, 16'h2222, waits, errs, stable);
    check("ior_tmo_waits", 32'(waits), 32'd16);
    check("ior_tmo_errs", 32'(errs), 32'd1);
    check("ior_tmo_dQ", 32'(dQ), 32'hFFFF);
    end_access();

    // Ack in the 15th IO_REQ cycle wins over the timeout
    io_access(1'b0, 8'hC8, 16'h0000, 15, 16'h1357, waits, errs, stable);
    check("ior_last_waits", 32'(waits), 32'd16);
    check("ior_last_errs", 32'(errs), 32'd0);
    check("ior_last_dQ", 32'(dQ), 32'h1357);
    end_access();

    // Reset in the 2nd IO_REQ cycle, then a late ack
    daddr = 8'hC1; mem_read = 1'b1; io_rdata = 16'h0F0F;
    tick();
    #1;
    check("rstx_req_c1", 32'(io_req), 32'd1);
    tick();
    reset = 1'b1; #1;
    check("rstx_wait_forced", 32'(wait_state), 32'd0);
    tick();
    reset = 1'b0;
    idle_inputs();
    io_ack = 1'b1; #1;
    check("rstx_req", 32'(io_req), 32'd0);
    check("rstx_dQ", 32'(dQ), 32'h0);
    check("rstx_wait", 32'(wait_state), 32'd0);
    tick();
    io_ack = 1'b0; #1;
    check("late_ack_dQ", 32'(dQ), 32'h0);
    check("late_ack_req", 32'(io_req), 32'd0);
    check("late_ack_err", 32'(io_err), 32'd0);

    // FSM back in IDLE: a fresh access completes normally
    io_access(1'b0, 8'hD2, 16'h0000, 1, 16'h4242, waits, errs, stable);
    check("post_rst_waits", 32'(waits), 32'd2);
    check("post_rst_dQ", 32'(dQ), 32'h4242);
    end_access();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
